// File: rtl/chipinvaders_pkg.sv
// Shared types for the chipinvaders button front end: button channel indices,
// auto-repeat FSM states and a small elaboration helper.
package chipinvaders_pkg;

    typedef enum logic [1:0] {
        BTN_LEFT  = 2'd0,
        BTN_RIGHT = 2'd1,
        BTN_SHOOT = 2'd2
    } btn_idx_e;

    localparam int N_BTN_C = 3;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } repeat_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: synchroniser, debouncer, press/release pulses and, when
// BUTTON_CONDITIONER_AUTOREPEAT_EN is defined, a hold-to-repeat FSM.
module button_debounce_ch
    import chipinvaders_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          raw_i,
    output logic          level_o,
    output logic          press_o,
    output logic          release_o,
    output repeat_state_e rpt_state_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Chain resets to the pad's released level so deassertion never looks like a press.
    localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{ACTIVE_LOW}};

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_debounce_ch: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   sync_lvl;
    logic                   acc_press, acc_release;
    logic                   rpt_fire;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], raw_i};
        sync_lvl    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
        cnt_d       = '0;
        lvl_d       = lvl_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        if (sync_lvl != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d       = sync_lvl;
                acc_press   = sync_lvl;
                acc_release = ~sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = acc_press | rpt_fire;
        rel_d   = acc_release;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= SYNC_RST;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int               TMR_W        = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST   = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    repeat_state_e    state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // A release accepted in the same cycle as a repeat tick wins: no pulse.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        rpt_fire = 1'b0;
        case (state_q)
            RPT_IDLE: begin
                if (acc_press) begin
                    state_d = RPT_DELAY;
                    tmr_d   = '0;
                end
            end
            RPT_DELAY: begin
                if (acc_release) begin
                    state_d = RPT_IDLE;
                end else if (tmr_q == DELAY_LAST) begin
                    rpt_fire = 1'b1;
                    state_d  = RPT_REPEAT;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (acc_release) begin
                    state_d = RPT_IDLE;
                end else if (tmr_q == PERIOD_LAST) begin
                    rpt_fire = 1'b1;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RPT_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    assign rpt_state_o = state_q;
`else
    assign rpt_fire    = 1'b0;
    assign rpt_state_o = RPT_IDLE;
`endif

    assign level_o   = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw button pads for the game core: one independent
// debounce channel per button. Auto-repeat via BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner
    import chipinvaders_pkg::*;
#(
    parameter int N_BTN           = N_BTN_C,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn_raw_i,
    output logic [N_BTN-1:0]   btn_level_o,
    output logic [N_BTN-1:0]   btn_press_o,
    output logic [N_BTN-1:0]   btn_release_o,
    output logic [2*N_BTN-1:0] rpt_state_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW != 0),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_i      (btn_raw_i[i]),
            .level_o    (btn_level_o[i]),
            .press_o    (btn_press_o[i]),
            .release_o  (btn_release_o[i]),
            .rpt_state_o(rpt_state_o[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pad activity,
// all checked against a sample-history reference model.
module tb_button_conditioner;
    import chipinvaders_pkg::*;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int EW   = 5 * N;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif
    localparam int L = int'(BTN_LEFT);
    localparam int R = int'(BTN_RIGHT);
    localparam int S = int'(BTN_SHOOT);

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   btn_raw_i = '0;
    logic [N-1:0]   btn_level_o, btn_press_o, btn_release_o;
    logic [2*N-1:0] rpt_state_o;

    button_conditioner #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_raw_i),
        .btn_level_o(btn_level_o), .btn_press_o(btn_press_o),
        .btn_release_o(btn_release_o), .rpt_state_o(rpt_state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // scoreboard
    logic [EW-1:0] exp_q[$];

    // reference model: raw pad history, accepted level, cycles held since acceptance
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl = '0;
    int           m_age[N];

    // observed event statistics for the directed scenarios
    int press_cnt[N], rel_cnt[N], first_press[N], last_press[N], last_rel[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [N-1:0]   e_prs, e_rel;
        logic [2*N-1:0] e_rpt;
        logic           s, run_ok;
        e_prs = '0;
        e_rel = '0;
        e_rpt = '0;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < DEB + SYNC; i++) hist.push_back('0);
            m_lvl = '0;
            for (int ch = 0; ch < N; ch++) m_age[ch] = 0;
        end else begin
            hist.push_back(btn_raw_i);
            for (int ch = 0; ch < N; ch++) begin
                // accept when the last DEB synchronised samples all disagree with the level
                s      = hist[hist.size() - 1 - SYNC][ch];
                run_ok = (s != m_lvl[ch]);
                for (int j = 1; j < DEB; j++)
                    if (hist[hist.size() - 1 - SYNC - j][ch] != s) run_ok = 1'b0;
                if (run_ok) begin
                    m_lvl[ch] = s;
                    if (s) begin
                        e_prs[ch] = 1'b1;
                        m_age[ch] = 0;
                    end else begin
                        e_rel[ch] = 1'b1;
                    end
                end else if (m_lvl[ch] && RPT_EN) begin
                    m_age[ch]++;
                    if (m_age[ch] == RD || (m_age[ch] > RD && (m_age[ch] - RD) % RP == 0))
                        e_prs[ch] = 1'b1;
                end
            end
            void'(hist.pop_front());
        end
        for (int ch = 0; ch < N; ch++)
            e_rpt[2*ch +: 2] = (RPT_EN && m_lvl[ch]) ?
                               ((m_age[ch] < RD) ? RPT_DELAY : RPT_REPEAT) : RPT_IDLE;
        exp_q.push_back({e_rpt, e_rel, e_prs, m_lvl});
    endtask

    task automatic clear_stats();
        for (int ch = 0; ch < N; ch++) begin
            press_cnt[ch]   = 0;
            rel_cnt[ch]     = 0;
            first_press[ch] = -1;
            last_press[ch]  = -1;
            last_rel[ch]    = -1;
        end
    endtask

    task automatic tick();
        logic [EW-1:0] w;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        w = exp_q.pop_front();
        check("level",     32'(btn_level_o),   32'(w[N-1:0]));
        check("press",     32'(btn_press_o),   32'(w[2*N-1:N]));
        check("release",   32'(btn_release_o), 32'(w[3*N-1:2*N]));
        check("rpt_state", 32'(rpt_state_o),   32'(w[5*N-1:3*N]));
        check("press_rel_excl", 32'(btn_press_o & btn_release_o), 32'd0);
        for (int ch = 0; ch < N; ch++) begin
            if (btn_press_o[ch]) begin
                press_cnt[ch]++;
                if (first_press[ch] < 0) first_press[ch] = cyc;
                last_press[ch] = cyc;
            end
            if (btn_release_o[ch]) begin
                rel_cnt[ch]++;
                last_rel[ch] = cyc;
            end
        end
    endtask

    task automatic assert_reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_level"},   32'(btn_level_o),   32'd0);
        check({tag, "_press"},   32'(btn_press_o),   32'd0);
        check({tag, "_release"}, 32'(btn_release_o), 32'd0);
    endtask

    function automatic int lat_tag(input int lat);
        return (lat >= 9 && lat <= 11) ? 10 : lat;
    endfunction

    initial begin
        int e, r, a;
        int hold[N];
        int rst_left;

        clear_stats();
        // reset state
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // clean press on LEFT
        repeat ($urandom_range(3, 8)) tick();
        clear_stats();
        e = cyc;
        btn_raw_i[L] = 1'b1;
        repeat (40) tick();
        check("clean_lat", 32'(lat_tag(first_press[L] - e)), 32'd10);
        check("clean_press_cnt", 32'(press_cnt[L]), RPT_EN ? 32'd4 : 32'd1);
        check("clean_no_rel", 32'(rel_cnt[L]), 32'd0);
        e = cyc;
        btn_raw_i[L] = 1'b0;
        repeat (15) tick();
        check("clean_rel_cnt", 32'(rel_cnt[L]), 32'd1);
        check("clean_rel_lat", 32'(lat_tag(last_rel[L] - e)), 32'd10);

        // bounce on RIGHT: 10 segments of 3 cycles, then hold 1
        repeat ($urandom_range(2, 6)) tick();
        clear_stats();
        for (int seg = 0; seg < 10; seg++) begin
            btn_raw_i[R] = (seg % 2 == 0);
            repeat (3) tick();
        end
        check("bounce_no_press", 32'(press_cnt[R]), 32'd0);
        check("bounce_no_rel", 32'(rel_cnt[R]), 32'd0);
        e = cyc;
        btn_raw_i[R] = 1'b1;
        repeat (20) tick();
        check("bounce_lat", 32'(lat_tag(first_press[R] - e)), 32'd10);
        check("bounce_press_cnt", 32'(press_cnt[R]), 32'd1);
        btn_raw_i[R] = 1'b0;
        repeat (15) tick();

        // glitch of 7 cycles on SHOOT: ignored
        clear_stats();
        btn_raw_i[S] = 1'b1;
        repeat (7) tick();
        btn_raw_i[S] = 1'b0;
        repeat (20) tick();
        check("glitch_no_press", 32'(press_cnt[S]), 32'd0);
        check("glitch_no_rel", 32'(rel_cnt[S]), 32'd0);

        // exactly DEBOUNCE_CYCLES wide: accepted
        clear_stats();
        btn_raw_i[S] = 1'b1;
        repeat (DEB) tick();
        btn_raw_i[S] = 1'b0;
        repeat (20) tick();
        check("edge8_press", 32'(press_cnt[S]), 32'd1);
        check("edge8_rel", 32'(rel_cnt[S]), 32'd1);

        // independence: LEFT, SHOOT 2 cycles later, released together
        clear_stats();
        btn_raw_i[L] = 1'b1;
        repeat (2) tick();
        btn_raw_i[S] = 1'b1;
        repeat (20) tick();
        btn_raw_i[L] = 1'b0;
        btn_raw_i[S] = 1'b0;
        repeat (15) tick();
        check("indep_press_gap", 32'(first_press[S] - first_press[L]), 32'd2);
        check("indep_rel_left", 32'(rel_cnt[L]), 32'd1);
        check("indep_rel_shoot", 32'(rel_cnt[S]), 32'd1);
        check("indep_rel_same", 32'(last_rel[S] - last_rel[L]), 32'd0);

        // reset mid-debounce
        clear_stats();
        btn_raw_i[L] = 1'b1;
        repeat (5) tick();
        assert_reset_now("rst_mid");
        repeat (3) tick();
        rst_n = 1'b1;
        r = cyc;
        repeat (15) tick();
        check("rst_mid_lat", 32'(lat_tag(first_press[L] - r)), 32'd10);
        check("rst_mid_press_cnt", 32'(press_cnt[L]), 32'd1);
        check("rst_mid_no_rel", 32'(rel_cnt[L]), 32'd0);
        btn_raw_i[L] = 1'b0;
        repeat (15) tick();

        // reset while held: no release pulse afterwards
        btn_raw_i[R] = 1'b1;
        repeat (15) tick();
        clear_stats();
        assert_reset_now("rst_held");
        repeat (2) tick();
        rst_n = 1'b1;
        btn_raw_i[R] = 1'b0;
        repeat (15) tick();
        check("rst_held_no_rel", 32'(rel_cnt[R]), 32'd0);
        check("rst_held_no_press", 32'(press_cnt[R]), 32'd0);

        // hold RIGHT 60 cycles after acceptance
        clear_stats();
        btn_raw_i[R] = 1'b1;
        for (int k = 0; k < 20 && !btn_level_o[R]; k++) tick();
        check("hold_accepted", 32'(btn_level_o[R]), 32'd1);
        a = cyc;
        repeat (50) tick();
        btn_raw_i[R] = 1'b0;
        repeat (20) tick();
        check("hold_press_cnt", 32'(press_cnt[R]), RPT_EN ? 32'd9 : 32'd1);
        check("hold_last_press", 32'(last_press[R] - a), RPT_EN ? 32'd55 : 32'd0);
        check("hold_rel_cnt", 32'(rel_cnt[R]), 32'd1);
        check("hold_rel_at", 32'(last_rel[R] - a), 32'd60);

        // random pad activity with occasional resets
        for (int ch = 0; ch < N; ch++) hold[ch] = $urandom_range(1, 20);
        rst_left = 0;
        repeat (1500) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    btn_raw_i[ch] = ~btn_raw_i[ch];
                    hold[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : $urandom_range(8, 40);
                end else begin
                    hold[ch]--;
                end
            end
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
            tick();
        end
        rst_n = 1'b1;
        btn_raw_i = '0;
        repeat (60) tick();
        check("final_level", 32'(btn_level_o), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
